// File: rtl/hack_pkg.sv
// hack_pkg: shared widths, depths and the RAM8 FSM state type for the hack RAM hierarchy
package hack_pkg;
    localparam int WORD_W      = 16;
    localparam int RAM8_ADDR_W = 3;
    localparam int RAM8_DEPTH  = 8;
    typedef enum logic {SCRUB, READY} ram8_state_t;
endpackage

// File: rtl/hack_register.sv
// hack_register: WIDTH-bit storage word with load enable and no reset
module hack_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;
    // capture d_i only on an enabled edge; contents are initialised by the owner's scrub
    always_ff @(posedge clk) begin
        if (load_i) data_q <= d_i;
    end
    assign q_o = data_q;
endmodule

// File: rtl/ram8_bank.sv
// ram8_bank: 8-word register bank with post-reset/clear scrub; RAM8_BANK_BYPASS_EN enables write-through read
module ram8_bank
    import hack_pkg::*;
#(
    parameter int               WIDTH       = WORD_W,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    input  logic                   clear,
    output logic [WIDTH-1:0]       out,
    output logic                   busy
);
    ram8_state_t            state_q, state_d;
    logic [RAM8_ADDR_W-1:0] cnt_q, cnt_d;
    logic                   scrub, user_wr, eff_load;
    logic [RAM8_ADDR_W-1:0] eff_addr;
    logic [WIDTH-1:0]       eff_data, rd_word;
    logic [RAM8_DEPTH-1:0]  we;
    logic [WIDTH-1:0]       words [RAM8_DEPTH];

    assign scrub    = (state_q == SCRUB);
    assign busy     = scrub;
    assign user_wr  = load && !clear;
    assign eff_load = rst_n && (scrub || user_wr);
    assign eff_addr = scrub ? cnt_q : address;
    assign eff_data = scrub ? CLEAR_VALUE : in;
    assign we       = eff_load ? (RAM8_DEPTH'(1) << eff_addr) : '0;

    // scrub walks cnt 0..7 then releases; clear (re)starts the walk from word 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (scrub) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == RAM8_ADDR_W'(RAM8_DEPTH - 1)) ? READY : SCRUB;
        end
        if (clear) begin
            state_d = SCRUB;
            cnt_d   = '0;
        end
    end

    // sequencer state; reset forces a fresh scrub from word 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SCRUB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
        hack_register #(.WIDTH(WIDTH)) u_word (
            .clk    (clk),
            .load_i (we[i]),
            .d_i    (eff_data),
            .q_o    (words[i])
        );
    end

`ifdef RAM8_BANK_BYPASS_EN
    assign rd_word = user_wr ? in : words[address];
`else
    assign rd_word = words[address];
`endif
    assign out = busy ? CLEAR_VALUE : rd_word;
endmodule

// File: tb/tb_ram8_bank.sv
// tb_ram8_bank: randomized and directed checks of ram8_bank against a word-array reference model
module tb_ram8_bank;
    logic        clk = 0;
    logic        rst_n;
    logic [15:0] din;
    logic        load;
    logic [2:0]  address;
    logic        clear;
    logic [15:0] dout;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] mem [8];
    int          scrub_left;

    ram8_bank dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (din),
        .load    (load),
        .address (address),
        .clear   (clear),
        .out     (dout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_out();
        if (scrub_left > 0) return 16'h0000;
`ifdef RAM8_BANK_BYPASS_EN
        if (load && !clear) return din;
`endif
        return mem[address];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n || clear) scrub_left = 8;
        else if (scrub_left > 0) scrub_left--;
        else if (load) mem[address] = din;
        if (scrub_left == 8) for (int k = 0; k < 8; k++) mem[k] = 16'h0000;
        @(negedge clk);
    endtask

    task automatic idle();
        load = 0; clear = 0; din = 16'h0000;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; din = d; load = 1; clear = 0;
        tick();
        load = 0;
    endtask

    task automatic count_busy(input string name, input int want);
        int n = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (busy === 1'b1) n++;
            tick();
        end
        checks++;
        if (n !== want) begin errors++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, n, want); end
    endtask

    task automatic read_all(input string name, input logic [2:0] hot, input logic [15:0] hot_val);
        load = 0; clear = 0;
        for (int k = 0; k < 8; k++) begin
            address = 3'(k);
            #1;
            checks++;
            if (dout !== ((3'(k) == hot) ? hot_val : 16'h0000)) begin
                errors++; $display("FAIL %s addr=%0d got=%h want=%h", name, k, dout, (3'(k) == hot) ? hot_val : 16'h0000);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); address = 3'(($urandom));
        tick(); tick();
        #1; checks++;
        if (busy !== 1'b1 || dout !== 16'h0000) begin errors++; $display("FAIL reset_hold busy=%b out=%h want busy=1 out=0000", busy, dout); end
        rst_n = 1;
        count_busy("reset_release", 8);
        read_all("reset_read", 3'd0, 16'h0000);
    endtask

    task automatic test_write_one();
        wr(3'd3, 16'hBEEF);
        read_all("write3", 3'd3, 16'hBEEF);
    endtask

    task automatic test_clear_priority();
        for (int k = 0; k < 8; k++) wr(3'(k), 16'(16'h1111 * k));
        address = 3'd5; #1; checks++;
        if (dout !== 16'h5555) begin errors++; $display("FAIL prefill addr5 got=%h want=5555", dout); end
        address = 3'd5; din = 16'hFFFF; load = 1; clear = 1;
        tick();
        idle();
        count_busy("clear_scrub", 8);
        read_all("clear_read", 3'd5, 16'h0000);
    endtask

    task automatic test_load_busy();
        clear = 1; tick(); clear = 0;
        address = 3'd2; din = 16'h1234; load = 1;
        for (int i = 0; i < 8; i++) tick();
        idle();
        #1; checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_end busy got=%b want=0", busy); end
        read_all("load_busy_read", 3'd2, 16'h0000);
    endtask

    task automatic test_reset_mid();
        wr(3'd1, 16'h7777);
        clear = 1; tick(); clear = 0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 0; tick(); rst_n = 1;
        count_busy("reset_mid", 8);
        read_all("reset_mid_read", 3'd1, 16'h0000);
    endtask

    task automatic test_bypass();
        logic [15:0] want_now;
        wr(3'd6, 16'h5A5A);
        address = 3'd6; din = 16'hA5A5; load = 1;
`ifdef RAM8_BANK_BYPASS_EN
        want_now = 16'hA5A5;
`else
        want_now = 16'h5A5A;
`endif
        #1; checks++;
        if (dout !== want_now) begin errors++; $display("FAIL same_cycle got=%h want=%h", dout, want_now); end
        tick(); load = 0;
        #1; checks++;
        if (dout !== 16'hA5A5) begin errors++; $display("FAIL next_cycle got=%h want=a5a5", dout); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            din = 16'($urandom); address = 3'($urandom_range(7)); load = 1'($urandom);
            clear = ($urandom_range(31) == 0);
            rst_n = ($urandom_range(99) != 0);
            #1; checks++;
            if (busy !== (scrub_left > 0)) begin errors++; $display("FAIL rand_busy i=%0d got=%b want=%b", i, busy, scrub_left > 0); end
            checks++;
            if (dout !== exp_out()) begin errors++; $display("FAIL rand_out i=%0d addr=%0d got=%h want=%h", i, address, dout, exp_out()); end
            tick();
        end
        rst_n = 1; idle();
    endtask

    initial begin
        scrub_left = 8;
        for (int k = 0; k < 8; k++) mem[k] = 16'h0000;
        rst_n = 0; idle(); address = 3'd0;
        @(negedge clk);
        test_reset();
        test_write_one();
        test_clear_priority();
        test_load_busy();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram8_bank.md
Name: ram8_bank

Overview:
- 8-word x WIDTH-bit register bank; the downstream consumer of the 8-way load demultiplexer.
- The single `load` is steered by `address` to exactly one word register. `out` is multiplexed back from the addressed word.
- A post-reset scrub sequencer clears every word through the same single write path, one word per cycle, before accepting user writes.
- Building block for the larger RAM hierarchy.

Parameters:
WIDTH, 16, data word width in bits
CLEAR_VALUE, 0, value written into every word during a scrub

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in  input  WIDTH  write data
load  input  1  write strobe for the addressed word
address  input  3  word select for write and read
clear  input  1  one-cycle request to re-scrub the whole bank
out  output  WIDTH  read data of word[address]
busy  output  1  high while scrubbing; user writes ignored

Behaviour:
- Reset (rst_n=0 at a rising edge): FSM enters SCRUB, scrub counter = 0, busy = 1.
  - Word registers are not reset directly; they are cleared by the scrub.
  - `out` is forced to CLEAR_VALUE while busy = 1.
- States:
  - SCRUB: each cycle, word[cnt] <= CLEAR_VALUE, cnt <= cnt+1. When cnt==7 is written, next state is READY and busy goes 0 on the following cycle. A full scrub takes exactly 8 cycles from reset release.
  - READY: if load=1, word[address] <= in at the rising edge. All other words hold.
- Write routing:
  - Exactly one word is enabled per cycle: dmux of the effective load by the effective address.
  - Effective signals in SCRUB: load=1, address=cnt.
  - Effective signals in READY: user load and user address.
- Read path:
  - READY: out = word[address], combinational; no read latency.
  - A write at edge N is visible on `out` from edge N onward. The same-cycle read returns the old value (see Optional Feature for the exception).
- clear:
  - In READY, clear=1 moves the FSM to SCRUB with cnt=0 at the next edge.
  - clear has priority over a simultaneous load; that load is dropped and no word is written.
  - clear during SCRUB restarts the scrub at cnt=0.
- Reset mid-scrub or mid-write: reset wins; the scrub restarts at cnt=0.
- Counter arithmetic: cnt is 3-bit. The 7->0 wrap is coincident with the SCRUB->READY transition.
- No X on `out` after reset release, at any address.

Optional Feature:
- Macro: RAM8_BANK_BYPASS_EN.
- Defined: in READY, when load=1, `out` = `in` for the same address in the same cycle (write-through bypass). While busy, `out` is still CLEAR_VALUE.
- Undefined: `out` always shows the stored word; the new value appears after the edge.

Decomposition:
- Shared package hack_pkg holds:
  - WORD_W=16, RAM8_ADDR_W=3, RAM8_DEPTH=8
  - ram8_state_t enum {SCRUB, READY}
- One sub-module: hack_register, a WIDTH-bit register with load enable and no reset. Instantiate it 8 times.
- Reuse the existing 8-way demux for load steering and the 8-way 16-bit mux for the read path.

Test Plan:
- Reset release -> busy=1 for exactly 8 cycles, then 0. Reading addresses 0..7 afterwards returns 0x0000 each.
- Write address 3 with 0xBEEF at load=1, then read addresses 0..7 -> only address 3 returns 0xBEEF; the rest return 0x0000.
- Write addresses 0..7 with 0x1111*k, then clear=1 concurrent with load=1, address 5, data 0xFFFF -> 8 busy cycles, all words 0x0000, 0xFFFF never stored.
- load=1 while busy, address 2, data 0x1234 -> ignored; address 2 reads 0x0000 after the scrub.
- Assert rst_n=0 at scrub cycle 4 -> scrub restarts; busy lasts 8 cycles from the new release.
- Same-cycle write 0xA5A5 to address 6 while reading address 6 -> out=0xA5A5 with RAM8_BANK_BYPASS_EN defined, the old value without it. The next cycle reads 0xA5A5 in both builds.
